universal_counter: RTL and testbench



---
 rtl/universal_counter.sv | 100 ++++++++++
 tb/tb_universal_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_counter.sv
// Modulo-MOD up/down counter with universal shift datapath.
// Ports: clk, reset (sync, active-high), enable, load, load_val, mode,
// up_dn, step, msb_in, lsb_in -> count, tc, overflow (all registered).
// Option: UNIVERSAL_COUNTER_SATURATE_EN clamps instead of wrapping.
module universal_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] step,
  input  logic             msb_in,
  input  logic             lsb_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow
);

  localparam logic [WIDTH:0]   MODX = (WIDTH+1)'(MOD);
  // Truncates to 0 when MOD == 2**WIDTH; the
  // WIDTH-bit arithmetic below is still exact.
  localparam logic [WIDTH-1:0] MODW = WIDTH'(MOD);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] se;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] nxt;
  logic             nxt_tc;

  always_comb begin
    se = ({1'b0, step} >= MODX) ? MAXV : step;
    sum = {1'b0, count} + {1'b0, se};
    r = mode[0] ? {count[WIDTH-2:0], lsb_in}
                : {msb_in, count[WIDTH-1:1]};
  end

  always_comb begin
    nxt    = count;
    nxt_tc = 1'b0;
    if (enable) begin
      unique case (mode)
        2'b01: begin
          if (se != '0) begin
            if (up_dn) begin
              if (sum >= MODX) begin
                nxt_tc = 1'b1;
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
                nxt = MAXV;
`else
                nxt = sum[WIDTH-1:0] - MODW;
`endif
              end else begin
                nxt = sum[WIDTH-1:0];
              end
            end else begin
              if (count < se) begin
                nxt_tc = 1'b1;
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
                nxt = '0;
`else
                nxt = count + MODW - se;
`endif
              end else begin
                nxt = count - se;
              end
            end
          end
        end
        2'b10, 2'b11: begin
          nxt = ({1'b0, r} >= MODX) ? r - MODW : r;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      count    <= ({1'b0, load_val} >= MODX)
                  ? MAXV : load_val;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count <= nxt;
      tc    <= nxt_tc;
      if (nxt_tc) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_universal_counter.sv
// Self-checking bench for universal_counter (WIDTH=4, MOD=10).
// Reference model in integer arithmetic plus directed literal checks.
module tb_universal_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'b00;
  logic         up_dn = 1'b1;
  logic [W-1:0] step = '0;
  logic         msb_in = 1'b0;
  logic         lsb_in = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  int m_c = 0;
  int m_t = 0;
  int m_o = 0;
  bit armed = 1'b0;

  universal_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .load(load), .load_val(load_val), .mode(mode),
    .up_dn(up_dn), .step(step), .msb_in(msb_in),
    .lsb_in(lsb_in), .count(count), .tc(tc),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Behavioural model, straight from the rules.
  always @(posedge clk) begin
    int se, s, r;
    if (reset) begin
      m_c = 0; m_t = 0; m_o = 0;
      armed = 1'b1;
    end else if (load) begin
      m_c = (int'(load_val) >= M) ? M - 1 : int'(load_val);
      m_t = 0; m_o = 0;
    end else if (!enable || mode == 2'b00) begin
      m_t = 0;
    end else if (mode == 2'b01) begin
      se = (int'(step) >= M) ? M - 1 : int'(step);
      m_t = 0;
      if (se != 0) begin
        if (up_dn) begin
          s = m_c + se;
          if (s >= M) begin
            m_t = 1;
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
            m_c = M - 1;
`else
            m_c = s - M;
`endif
          end else m_c = s;
        end else begin
          if (m_c < se) begin
            m_t = 1;
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
            m_c = 0;
`else
            m_c = m_c + M - se;
`endif
          end else m_c = m_c - se;
        end
      end
    end else begin
      if (mode == 2'b10)
        r = int'(msb_in) * (2 ** (W - 1)) + m_c / 2;
      else
        r = (m_c * 2) % (2 ** W) + int'(lsb_in);
      m_c = (r >= M) ? r - M : r;
      m_t = 0;
    end
    if (m_t != 0) m_o = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_count", int'(count), m_c);
      chk("model_tc", int'(tc), m_t);
      chk("model_ovf", int'(overflow), m_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = W'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic cnt(input bit up, input int s);
    enable = 1'b1; mode = 2'b01;
    up_dn = up; step = W'(s);
  endtask

  initial begin
    // 1: reset beats load and count
    reset = 1'b1; load = 1'b1; load_val = 4'd5;
    enable = 1'b1; mode = 2'b01; step = 4'd1;
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0; load = 1'b0; enable = 1'b0;

`ifndef UNIVERSAL_COUNTER_SATURATE_EN
    // 2: count up through wrap
    do_load(7);
    chk("ld7", int'(count), 7);
    cnt(1'b1, 1);
    tick(); chk("up8", int'(count), 8);
    chk("up8_tc", int'(tc), 0);
    tick(); chk("up9", int'(count), 9);
    tick(); chk("up0", int'(count), 0);
    chk("up0_tc", int'(tc), 1);
    chk("up0_ovf", int'(overflow), 1);
    tick(); chk("up1", int'(count), 1);
    chk("up1_tc", int'(tc), 0);
    chk("up1_ovf", int'(overflow), 1);
    enable = 1'b0;
    do_load(1);
    chk("ld_clr_ovf", int'(overflow), 0);
    // 3: count down wrap, clamped step
    cnt(1'b0, 3);
    tick(); chk("dn8", int'(count), 8);
    chk("dn8_tc", int'(tc), 1);
    step = 4'd15;
    tick(); chk("dn9", int'(count), 9);
    chk("dn9_tc", int'(tc), 1);
    enable = 1'b0;
`else
    // 6: saturating build
    do_load(9);
    cnt(1'b1, 2);
    tick(); chk("sat_hi", int'(count), 9);
    chk("sat_hi_tc", int'(tc), 1);
    enable = 1'b0;
    do_load(1);
    cnt(1'b0, 3);
    tick(); chk("sat_lo", int'(count), 0);
    chk("sat_lo_tc", int'(tc), 1);
    chk("sat_lo_ovf", int'(overflow), 1);
    enable = 1'b0;
`endif

    // 4: shifts with modulo fold
    do_load(6);
    enable = 1'b1; mode = 2'b11; lsb_in = 1'b1;
    tick(); chk("shl", int'(count), 3);
    chk("shl_tc", int'(tc), 0);
    enable = 1'b0;
    do_load(4);
    enable = 1'b1; mode = 2'b10; msb_in = 1'b1;
    tick(); chk("shr", int'(count), 0);
    chk("shr_tc", int'(tc), 0);
    // 5: load clamp, hold, load priority
    enable = 1'b0;
    do_load(12);
    chk("ld_clamp", int'(count), 9);
    mode = 2'b01; step = 4'd1; up_dn = 1'b1;
    tick(); chk("hold", int'(count), 9);
    chk("hold_tc", int'(tc), 0);
    enable = 1'b1;
    do_load(2);
    chk("ld_wins", int'(count), 2);
    chk("ld_wins_tc", int'(tc), 0);

    // random phase against the model
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 8);
      load_val = W'($urandom);
      enable   = ($urandom_range(0, 99) < 85);
      mode     = 2'($urandom);
      up_dn    = 1'($urandom);
      step     = W'($urandom);
      msb_in   = 1'($urandom);
      lsb_in   = 1'($urandom);
      tick();
    end
    reset = 1'b0; load = 1'b0; enable = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
